// File: rtl/wb_stage.sv
// Write-back stage: EX/WB register, write-back mux, register-bank write/forward port, retire counter.
// Latency: EX inputs to bank write is 1 cycle; stall holds the slot and masks the write, flush squashes the capture.
module wb_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     Saida_ULA,
    input  logic [DATA_W-1:0]     Saida_MemoriaDados,
    input  logic [DATA_W-1:0]     PC,
    input  logic [DATA_W-1:0]     constanteExtendida,
    input  logic [1:0]            wb_sel,
    input  logic                  wb_hab,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    output logic                  BR_Hab_Escrita,
    output logic [REG_ADDR_W-1:0] BR_Endereco_Escrita,
    output logic [DATA_W-1:0]     BR_Dado_Escrita,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_dest,
    output logic [DATA_W-1:0]     fwd_dado,
    output logic [CNT_W-1:0]      instr_retired
);

    localparam logic [1:0] SEL_ALU   = 2'b00;
    localparam logic [1:0] SEL_MEM   = 2'b01;
    localparam logic [1:0] SEL_LINK  = 2'b10;
    localparam logic [1:0] SEL_CONST = 2'b11;

    localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                  v_q,     v_d;
    logic [1:0]            sel_q,   sel_d;
    logic                  hab_q,   hab_d;
    logic [REG_ADDR_W-1:0] dest_q,  dest_d;
    logic [DATA_W-1:0]     alu_q,   alu_d;
    logic [DATA_W-1:0]     pc_q,    pc_d;
    logic [DATA_W-1:0]     const_q, const_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;

    logic                  retire;
    logic                  wr_en;
    logic [DATA_W-1:0]     wb_val;

    // Squashed slots keep their stale data fields; only v matters once cleared.
    always_comb begin
        v_d     = v_q;
        sel_d   = sel_q;
        hab_d   = hab_q;
        dest_d  = dest_q;
        alu_d   = alu_q;
        pc_d    = pc_q;
        const_d = const_q;
        if (flush) begin
            v_d = 1'b0;
        end else if (!stall) begin
            v_d     = ex_valid;
            sel_d   = wb_sel;
            hab_d   = wb_hab;
            dest_d  = wb_dest;
            alu_d   = Saida_ULA;
            pc_d    = PC;
            const_d = constanteExtendida;
        end
    end

    assign retire = v_q & ~stall;
    assign cnt_d  = retire ? cnt_q + CNT_ONE : cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v_q     <= 1'b0;
            sel_q   <= 2'b00;
            hab_q   <= 1'b0;
            dest_q  <= '0;
            alu_q   <= '0;
            pc_q    <= '0;
            const_q <= '0;
            cnt_q   <= '0;
        end else begin
            v_q     <= v_d;
            sel_q   <= sel_d;
            hab_q   <= hab_d;
            dest_q  <= dest_d;
            alu_q   <= alu_d;
            pc_q    <= pc_d;
            const_q <= const_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory read is synchronous, so its live data lines up with the registered slot.
    always_comb begin
        wb_val = alu_q;
        case (sel_q)
            SEL_ALU:   wb_val = alu_q;
            SEL_MEM:   wb_val = Saida_MemoriaDados;
            SEL_LINK:  wb_val = pc_q + DATA_ONE;
            SEL_CONST: wb_val = const_q;
            default:   wb_val = alu_q;
        endcase
    end

    assign wr_en               = v_q & hab_q & ~stall;
    assign BR_Hab_Escrita      = wr_en;
    assign BR_Endereco_Escrita = dest_q;
    assign BR_Dado_Escrita     = wb_val;
    assign fwd_valid           = wr_en;
    assign fwd_dest            = dest_q;
    assign fwd_dado            = wb_val;
    assign instr_retired       = cnt_q;

endmodule
